// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use/redirect/memory-wait hazard control FSM with saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  input  logic             dmem_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             pc_sel,
  output logic [31:0]      pc_target,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);
  typedef enum logic [1:0] {RUN = 2'd0, BUBBLE = 2'd1, REDIRECT = 2'd2, MEM_WAIT = 2'd3} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cycles_q, flush_events_q;
  logic             lu_haz, run_like, redir_acc;
  assign lu_haz = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  // MEM_WAIT releasing this cycle acts as RUN so a pending event is not dropped
  assign run_like = (state_q == RUN) || (state_q == BUBBLE) || (state_q == MEM_WAIT && !dmem_busy);
  always_comb begin
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    stall_ex   = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    pc_sel     = 1'b0;
    pc_target  = 32'd0;
    redir_acc  = 1'b0;
    state_d    = state_q;
    if (rst) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      state_d    = RUN;
    end else if (run_like) begin
      if (dmem_busy) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        stall_ex = 1'b1;
        state_d  = MEM_WAIT;
      end else if (ex_redirect) begin
        pc_sel     = 1'b1;
        pc_target  = ex_target;
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        redir_acc  = 1'b1;
        state_d    = REDIRECT;
      end else if (lu_haz && state_q != BUBBLE) begin
        stall_if   = 1'b1;
        stall_id   = 1'b1;
        flush_idex = 1'b1;
        state_d    = BUBBLE;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == MEM_WAIT) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      stall_ex = 1'b1;
    end else begin
      // kill the fetch already in flight from the synchronous imem
      flush_ifid = 1'b1;
      stall_if   = dmem_busy;
      stall_id   = dmem_busy;
      stall_ex   = dmem_busy;
      state_d    = dmem_busy ? REDIRECT : RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= (stall_if && !(&stall_cycles_q)) ? stall_cycles_q + CNT_W'(1) : stall_cycles_q;
      flush_events_q <= (redir_acc && !(&flush_events_q)) ? flush_events_q + CNT_W'(1) : flush_events_q;
    end
  end
  assign state        = state_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl with 4-bit counters.
module tb_pipe_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst, id_valid, id_use_rs1, id_use_rs2, ex_valid, ex_mem_read, ex_redirect, dmem_busy;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic [31:0] ex_target, pc_target;
  logic        stall_if, stall_id, stall_ex, flush_ifid, flush_idex, pc_sel;
  logic [1:0]  state;
  logic [3:0]  stall_cycles, flush_events;
  int          errors = 0;
  int          checks = 0;
  typedef struct {
    string       tag;
    logic [39:0] ctl;
    logic [3:0]  sc;
    logic [3:0]  fe;
  } exp_t;
  exp_t q[$];
  pipe_hazard_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_redirect(ex_redirect), .ex_target(ex_target), .dmem_busy(dmem_busy),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .pc_sel(pc_sel), .pc_target(pc_target), .state(state),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );
  always #5 clk = ~clk;
  function automatic logic [39:0] c(input logic si, input logic sd, input logic se, input logic fi,
                                    input logic fx, input logic ps, input logic [31:0] t, input logic [1:0] s);
    return {si, sd, se, fi, fx, ps, t, s};
  endfunction
  task automatic drv(input logic r, input logic b, input logic rd, input logic [31:0] t, input logic lu);
    rst = r; dmem_busy = b; ex_redirect = rd; ex_target = t;
    id_valid = lu; id_rs1 = 5'd5; id_use_rs1 = lu; id_rs2 = 5'd0; id_use_rs2 = 1'b0;
    ex_valid = lu; ex_rd = 5'd5; ex_mem_read = lu;
  endtask
  task automatic step(input string tag, input logic [39:0] ctl, input int sc, input int fe);
    exp_t e;
    logic [39:0] obs;
    q.push_back('{tag, ctl, 4'(sc), 4'(fe)});
    #2;
    checks++;
    assert (q.size() != 0) else begin errors++; $error("FAIL %s scoreboard empty", tag); end
    if (q.size() != 0) begin
      e = q.pop_front();
      obs = {stall_if, stall_id, stall_ex, flush_ifid, flush_idex, pc_sel, pc_target, state};
      checks++;
      assert (obs === e.ctl) else begin errors++; $error("FAIL %s ctl got %h want %h", e.tag, obs, e.ctl); end
      checks++;
      assert (stall_cycles === e.sc) else begin errors++; $error("FAIL %s stall_cycles got %0d want %0d", e.tag, stall_cycles, e.sc); end
      checks++;
      assert (flush_events === e.fe) else begin errors++; $error("FAIL %s flush_events got %0d want %0d", e.tag, flush_events, e.fe); end
    end
    @(negedge clk);
  endtask
  initial begin
    drv(1, 1, 1, 32'h44, 1);
    @(negedge clk);
    step("rst_out", c(0,0,0,1,1,0,0,0), 0, 0);
    drv(0, 0, 0, 0, 1);
    step("lu_stall", c(1,1,0,0,1,0,0,0), 0, 0);
    step("lu_bubble_masked", c(0,0,0,0,0,0,0,1), 1, 0);
    drv(0, 0, 0, 0, 0);
    step("lu_back_run", c(0,0,0,0,0,0,0,0), 1, 0);
    drv(0, 0, 0, 0, 1); ex_rd = 5'd0; id_rs1 = 5'd0;
    step("x0_filter", c(0,0,0,0,0,0,0,0), 1, 0);
    step("x0_stay_run", c(0,0,0,0,0,0,0,0), 1, 0);
    drv(0, 0, 0, 0, 1); id_rs1 = 5'd3; id_rs2 = 5'd7; id_use_rs2 = 1'b1; ex_rd = 5'd7;
    step("rs2_stall", c(1,1,0,0,1,0,0,0), 1, 0);
    drv(0, 0, 0, 0, 0);
    step("rs2_bubble", c(0,0,0,0,0,0,0,1), 2, 0);
    step("rs2_run", c(0,0,0,0,0,0,0,0), 2, 0);
    drv(0, 0, 0, 0, 1); ex_mem_read = 1'b0;
    step("no_memread", c(0,0,0,0,0,0,0,0), 2, 0);
    drv(0, 0, 1, 32'h20, 0);
    step("redir_take", c(0,0,0,1,1,1,32'h20,0), 2, 0);
    drv(0, 0, 1, 32'h40, 1);
    step("redir_ignore", c(0,0,0,1,0,0,0,2), 2, 1);
    drv(0, 0, 0, 0, 0);
    step("redir_run", c(0,0,0,0,0,0,0,0), 2, 1);
    drv(0, 1, 1, 32'h80, 1);
    step("prio_freeze", c(1,1,1,0,0,0,0,0), 2, 1);
    step("memwait_1", c(1,1,1,0,0,0,0,3), 3, 1);
    step("memwait_2", c(1,1,1,0,0,0,0,3), 4, 1);
    drv(0, 0, 1, 32'h80, 1);
    step("memwait_release_redir", c(0,0,0,1,1,1,32'h80,3), 5, 1);
    drv(0, 0, 0, 0, 0);
    step("after_release_redir", c(0,0,0,1,0,0,0,2), 5, 2);
    step("after_release_run", c(0,0,0,0,0,0,0,0), 5, 2);
    drv(0, 0, 1, 32'h100, 0);
    step("redir2_take", c(0,0,0,1,1,1,32'h100,0), 5, 2);
    drv(0, 1, 0, 0, 0);
    step("redirect_busy", c(1,1,1,1,0,0,0,2), 5, 3);
    drv(0, 0, 0, 0, 0);
    step("redirect_release", c(0,0,0,1,0,0,0,2), 6, 3);
    step("redirect_run", c(0,0,0,0,0,0,0,0), 6, 3);
    drv(0, 1, 0, 0, 1);
    step("busy_with_haz", c(1,1,1,0,0,0,0,0), 6, 3);
    drv(0, 0, 0, 0, 1);
    step("memwait_release_haz", c(1,1,0,0,1,0,0,3), 7, 3);
    step("haz_bubble", c(0,0,0,0,0,0,0,1), 8, 3);
    drv(0, 0, 0, 0, 0);
    step("haz_run", c(0,0,0,0,0,0,0,0), 8, 3);
    drv(0, 1, 0, 0, 0);
    step("pre_rst_busy", c(1,1,1,0,0,0,0,0), 8, 3);
    drv(1, 1, 0, 0, 0);
    step("rst_in_memwait", c(0,0,0,1,1,0,0,3), 9, 3);
    drv(1, 1, 1, 32'h55, 1);
    step("rst_held", c(0,0,0,1,1,0,0,0), 0, 0);
    drv(0, 0, 0, 0, 0);
    step("rst_release", c(0,0,0,0,0,0,0,0), 0, 0);
    drv(0, 1, 0, 0, 0);
    for (int k = 0; k < 20; k++)
      step("sat_stall", c(1,1,1,0,0,0,0,(k == 0) ? 2'd0 : 2'd3), (k > 15) ? 15 : k, 0);
    drv(0, 0, 0, 0, 0);
    step("sat_release", c(0,0,0,0,0,0,0,3), 15, 0);
    step("sat_run", c(0,0,0,0,0,0,0,0), 15, 0);
    drv(0, 0, 1, 32'h200, 0);
    for (int i = 0; i < 17; i++) begin
      step("fe_take", c(0,0,0,1,1,1,32'h200,0), 15, (i > 15) ? 15 : i);
      step("fe_redirect", c(0,0,0,1,0,0,0,2), 15, (i + 1 > 15) ? 15 : i + 1);
    end
    drv(0, 0, 0, 0, 0);
    step("fe_sat_run", c(0,0,0,0,0,0,0,0), 15, 15);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
